// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// The unit runs one radix-2 step per cycle on operand magnitudes and applies
// the sign correction when it loads the result.
// Handshake: start is sampled only in IDLE. stall is high from the accepting
// cycle through the last CALC cycle. done is a one-cycle pulse, with result
// valid in that same cycle. flush aborts any operation without producing done.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;       // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [CW-1:0]      count;
  logic               neg_q;     // negate product or quotient
  logic               neg_r;     // negate remainder (dividend sign)

  logic               is_div, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   special_res;

  // Decode the incoming operation: signedness, magnitudes and the divide special cases.
  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && op_a[WIDTH-1];
    b_neg    = b_signed && op_b[WIDTH-1];
    a_abs    = a_neg ? -op_a : op_a;
    b_abs    = b_neg ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? op_a : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : op_a;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_mag};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (op_q[2]) begin
      // Remainder stays below b_mag, so a clear borrow bit means the subtract fits.
      if (!div_diff[WIDTH])
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, calc_res;

  // Sign-correct the value produced by the final step and select the requested word.
  always_comb begin
    prod = neg_q ? -acc_next : acc_next;
    quo  = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem  = neg_r ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:                 calc_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         calc_res = quo;
      default:                calc_res = rem;
    endcase
  end

  // Freeze the pipeline from the accepting cycle through the last iteration.
  always_comb begin
    stall = rstn && (((state == IDLE) && start && !flush) || (state == CALC));
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      op_q   <= '0;
      b_mag  <= '0;
      acc    <= '0;
      count  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= funct3;
            b_mag <= b_abs;
            acc   <= {{WIDTH{1'b0}}, a_abs};
            count <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (div_zero || div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (count == CW'(WIDTH-1)) begin
              result <= calc_res;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, flush/reset
// aborts, back-to-back issue and randomized operations against an
// arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         stall;
  logic         done;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: RV32M arithmetic using plain 64-bit math.
  function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == '0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == '0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == '0) return a;  p = sa % sb; return p[31:0]; end
      default: begin if (b == '0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Cycles from the accepting edge to the done cycle.
  function automatic int exp_latency(input logic [2:0] f, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (f[2] && b == '0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  // Driver: issue one op, follow it to done, check latency, stall and result.
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    int lat;
    int stall_bad;
    logic [W-1:0] exp_res;
    logic [W-1:0] held;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; flush = 1'b0;
    #1;
    check("stall_on_start", {31'b0, stall}, 32'd1);
    exp_q.push_back(ref_model(f, a, b));
    lat = exp_latency(f, a, b);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    k = 1;
    stall_bad = 0;
    while (!done && k < 40) begin
      if (stall !== 1'b1) stall_bad++;
      @(negedge clk);
      k++;
    end
    exp_res = exp_q.pop_front();
    check("stall_busy_errors", 32'(stall_bad), 32'd0);
    if (!done) begin
      check("done_timeout", {31'b0, done}, 32'd1);
    end else begin
      check("latency", 32'(k), 32'(lat));
      check("stall_in_done", {31'b0, stall}, 32'd0);
      check("result", result, exp_res);
      held = result;
      @(negedge clk);
      check("done_one_cycle", {31'b0, done}, 32'd0);
      check("result_hold", result, held);
    end
  endtask

  logic [2:0]   vf [0:11];
  logic [W-1:0] va [0:11];
  logic [W-1:0] vb [0:11];

  initial begin
    int t1;
    int t2;
    int done_cnt;
    logic [W-1:0] held;
    logic [2:0]   rf;
    logic [W-1:0] ra, rb;

    // Directed vectors
    vf[0]  = 3'd0; va[0]  = 32'd7;          vb[0]  = 32'hFFFF_FFFD;
    vf[1]  = 3'd1; va[1]  = 32'h8000_0000;  vb[1]  = 32'h8000_0000;
    vf[2]  = 3'd3; va[2]  = 32'hFFFF_FFFF;  vb[2]  = 32'hFFFF_FFFF;
    vf[3]  = 3'd5; va[3]  = 32'd100;        vb[3]  = 32'd7;
    vf[4]  = 3'd7; va[4]  = 32'd100;        vb[4]  = 32'd7;
    vf[5]  = 3'd4; va[5]  = 32'hFFFF_FFF9;  vb[5]  = 32'd2;
    vf[6]  = 3'd6; va[6]  = 32'hFFFF_FFF9;  vb[6]  = 32'd2;
    vf[7]  = 3'd4; va[7]  = 32'd5;          vb[7]  = 32'd0;
    vf[8]  = 3'd7; va[8]  = 32'd5;          vb[8]  = 32'd0;
    vf[9]  = 3'd4; va[9]  = 32'h8000_0000;  vb[9]  = 32'hFFFF_FFFF;
    vf[10] = 3'd6; va[10] = 32'h8000_0000;  vb[10] = 32'hFFFF_FFFF;
    vf[11] = 3'd2; va[11] = 32'hFFFF_FFFE;  vb[11] = 32'hFFFF_FFFF;

    // Reset with start held high
    rstn = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    start = 1'b0;
    rstn = 1'b1;
    #1;
    check("idle_stall", {31'b0, stall}, 32'd0);

    for (int i = 0; i < 12; i++) run_op(vf[i], va[i], vb[i]);

    // start together with flush is not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
    #1;
    check("start_flush_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("start_flush_not_taken", {30'b0, stall, done}, 32'd0);

    // Flush in the middle of a divide
    @(negedge clk);
    held = result;
    start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_stall", {31'b0, stall}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("flush_no_done", 32'(done_cnt), 32'd0);
    check("flush_result_kept", result, held);
    run_op(3'd0, 32'd3, 32'd4);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; funct3 = 3'd1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midop_reset_outputs", {stall, done, 30'b0}, 32'd0);
    check("midop_reset_result", result, 32'd0);
    rstn = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midop_reset_no_done", 32'(done_cnt), 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456;
    exp_q.push_back(ref_model(3'd0, 32'd123, 32'd456));
    exp_q.push_back(ref_model(3'd0, 32'd123, 32'd456));
    t1 = -1; t2 = -1;
    for (int i = 1; i < 100 && t2 < 0; i++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_result", result, exp_q.pop_front());
        if (t1 < 0) t1 = i;
        else begin
          t2 = i;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_spacing", 32'(t2 - t1), 32'd34);
    exp_q.delete();
    @(negedge clk);
    check("b2b_idle_stall", {31'b0, stall}, 32'd0);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
